// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
//   Iterative multiply/divide unit. Executes MULT, MULTU, DIV and DIVU on
//   WIDTH-bit operands, one result bit per cycle, and presents the HIGH/LOW
//   register values when the operation completes.
//
//   Signed operations run on operand magnitudes. The result signs are
//   captured at start and applied in a single fix-up cycle:
//     - The product is negated when the operand signs differ.
//     - The quotient truncates toward zero.
//     - The remainder takes the sign of the dividend.
//   DIV of the most negative value by -1 wraps: lo = min_neg, hi = 0.
//
// Parameters
//   WIDTH     operand width; hi and lo are each WIDTH bits (WIDTH >= 4)
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous reset, active-high; aborts any operation
//   start     request; sampled only while idle
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a         multiplicand / dividend (sampled with start)
//   b         multiplier / divisor (sampled with start)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse; hi/lo/div_zero are valid
//   hi        MULT: product[2W-1:W]; DIV: remainder
//   lo        MULT: product[W-1:0];  DIV: quotient
//   div_zero  set with done when a divide had b == 0; cleared on next start
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Operation context captured at start
  logic                 is_div;
  logic                 neg_res;   // negate product / quotient
  logic                 neg_rem;   // negate remainder
  logic                 dz_pend;   // divide by zero detected at start
  logic [CW-1:0]        cnt;

  // Datapath registers
  logic [WIDTH-1:0]     opnd;      // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0]   acc;       // product accumulator; multiplier in low half
  logic [WIDTH-1:0]     rem;       // partial remainder
  logic [WIDTH-1:0]     quo;       // dividend shifting out, quotient shifting in

  // Combinational datapath
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 zero_div;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    // op[0] selects unsigned mode; signs only matter for MULT/DIV
    sign_a   = ~op[0] & a[WIDTH-1];
    sign_b   = ~op[0] & b[WIDTH-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
    zero_div = op[1] && (b == '0);

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Restoring step: bring in the next dividend bit and try a subtraction.
    // The partial remainder stays below the divisor, so the borrow bit of the
    // W+1-bit trial alone tells whether the subtraction is kept.
    div_shift = {rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_ge    = ~div_trial[WIDTH];

    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = neg_rem ? -rem : rem;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          // A zero divisor skips RUN; FIX then leaves hi/lo untouched, which
          // places done two cycles after the start cycle.
          state_nxt = zero_div ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_pend  <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            dz_pend  <= zero_div;
            div_zero <= 1'b0;
            cnt      <= CW'(WIDTH - 1);
            opnd     <= op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, mag_b};
            rem      <= '0;
            quo      <= mag_a;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            rem <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          div_zero <= dz_pend;
          if (!dz_pend) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst32, start32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  // 8-bit instance
  logic        rst8, start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  muldiv_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  int total = 0;
  int bad   = 0;

  // Expected hi/lo currently held by each instance (index 0: 32-bit, 1: 8-bit)
  logic [63:0] prev_hi [2];
  logic [63:0] prev_lo [2];

  function automatic int wid(input bit s8);
    return s8 ? 8 : 32;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain wide arithmetic on the operand values
  function automatic void model(input int w, input logic [1:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] h, output logic [63:0] l,
                                output bit dz);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, mask;
    mask = wmask(w);
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin
        p = sa * sb;
        h = longint'(p >>> w) & mask;
        l = p & mask;
      end
      2'b01: begin
        up = ua * ub;
        h = (up >> w) & mask;
        l = up & mask;
      end
      2'b10: begin
        if (ub == 0) dz = 1'b1;
        else begin
          q = sa / sb;
          r = sa % sb;
          l = q & mask;
          h = r & mask;
        end
      end
      default: begin
        if (ub == 0) dz = 1'b1;
        else begin
          l = ua / ub;
          h = ua % ub;
        end
      end
    endcase
  endfunction

  task automatic drive(input bit s8, input logic st, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (s8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic set_rst(input bit s8, input logic v);
    if (s8) rst8 = v;
    else    rst32 = v;
  endtask

  task automatic obs(input bit s8, output logic bsy, output logic dn,
                     output logic dz, output logic [63:0] h, output logic [63:0] l);
    if (s8) begin
      bsy = busy8; dn = done8; dz = dz8;
      h = {56'd0, hi8}; l = {56'd0, lo8};
    end else begin
      bsy = busy32; dn = done32; dz = dz32;
      h = {32'd0, hi32}; l = {32'd0, lo32};
    end
  endtask

  // One full operation: latency, results, flag and the single done pulse
  task automatic run_op(input bit s8, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b, input string tag);
    int w, n, lat;
    logic bsy, dn, dz;
    logic [63:0] h, l, eh, el;
    bit edz;
    w = wid(s8);
    model(w, op, a, b, eh, el, edz);
    if (edz) begin
      eh = prev_hi[s8];
      el = prev_lo[s8];
    end
    lat = edz ? 2 : w + 2;
    @(negedge clk);
    drive(s8, 1'b1, op, a, b);
    @(negedge clk);
    // inputs scrambled after sampling; the operation must not notice
    drive(s8, 1'b0, 2'($urandom), {32'd0, $urandom}, {32'd0, $urandom});
    n = 1;
    obs(s8, bsy, dn, dz, h, l);
    total++;
    if (bsy !== 1'b1 || dz !== 1'b0) begin
      bad++;
      $display("FAIL %s w=%0d cycle1 busy/div_zero: got %b/%b want 1/0", tag, w, bsy, dz);
    end
    while (dn !== 1'b1 && n < w + 20) begin
      @(negedge clk);
      n++;
      obs(s8, bsy, dn, dz, h, l);
    end
    total++;
    if (n !== lat || dn !== 1'b1) begin
      bad++;
      $display("FAIL %s w=%0d latency: got %0d want %0d", tag, w, n, lat);
    end
    total++;
    if (h !== eh) begin
      bad++;
      $display("FAIL %s w=%0d hi: got %h want %h", tag, w, h, eh);
    end
    total++;
    if (l !== el) begin
      bad++;
      $display("FAIL %s w=%0d lo: got %h want %h", tag, w, l, el);
    end
    total++;
    if (dz !== edz) begin
      bad++;
      $display("FAIL %s w=%0d div_zero: got %b want %b", tag, w, dz, edz);
    end
    @(negedge clk);
    obs(s8, bsy, dn, dz, h, l);
    total++;
    if (dn !== 1'b0 || bsy !== 1'b0) begin
      bad++;
      $display("FAIL %s w=%0d after done busy/done: got %b/%b want 0/0", tag, w, bsy, dn);
    end
    prev_hi[s8] = eh;
    prev_lo[s8] = el;
  endtask

  task automatic test_reset;
    logic bsy, dn, dz;
    logic [63:0] h, l;
    rst32 = 1'b1; rst8 = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      obs(s[0], bsy, dn, dz, h, l);
      total++;
      if (bsy !== 1'b0 || dn !== 1'b0 || dz !== 1'b0 || h !== 64'd0 || l !== 64'd0) begin
        bad++;
        $display("FAIL reset w=%0d busy/done/dz/hi/lo: got %b/%b/%b/%h/%h want 0/0/0/0/0",
                 wid(s[0]), bsy, dn, dz, h, l);
      end
      prev_hi[s] = '0;
      prev_lo[s] = '0;
    end
    rst32 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_directed(input bit s8);
    logic [63:0] m, mn;
    m  = wmask(wid(s8));
    mn = 64'd1 << (wid(s8) - 1);
    run_op(s8, 2'b00, m - 64'd2, 64'd7,  "mult_neg3x7");
    run_op(s8, 2'b01, m,         m,      "multu_max");
    run_op(s8, 2'b10, m - 64'd6, 64'd2,  "div_neg7by2");
    run_op(s8, 2'b11, 64'd100,   64'd7,  "divu_100by7");
    run_op(s8, 2'b11, 64'd100,   64'd0,  "divu_by0");
    run_op(s8, 2'b10, m - 64'd6, 64'd0,  "div_by0");
    run_op(s8, 2'b10, mn,        m,      "div_minneg_by_m1");
    run_op(s8, 2'b00, mn,        mn,     "mult_minneg_sq");
    run_op(s8, 2'b10, m - 64'd6, m - 64'd1, "div_neg7_by_neg2");
  endtask

  task automatic test_random(input bit s8, input int count);
    logic [63:0] m, a, b;
    logic [1:0] op;
    int pick;
    m = wmask(wid(s8));
    for (int i = 0; i < count; i++) begin
      op   = 2'($urandom);
      a    = {32'd0, $urandom} & m;
      b    = {32'd0, $urandom} & m;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = '0;
      else if (pick == 1) begin a = 64'd1 << (wid(s8) - 1); b = m; end
      else if (pick == 2) b = {32'd0, $urandom_range(1, 3)} & m;
      run_op(s8, op, a, b, "random");
    end
  endtask

  // Start pulses mid-run and in the DONE cycle must both be ignored
  task automatic test_start_ignored(input bit s8);
    int w, mid, dcount, first;
    logic bsy, dn, dz;
    logic [63:0] h, l, eh, el, a, b;
    bit edz;
    w   = wid(s8);
    mid = s8 ? 5 : 10;
    a   = wmask(w) - 64'd2;
    b   = 64'd7;
    model(w, 2'b00, a, b, eh, el, edz);
    dcount = 0;
    first  = 0;
    @(negedge clk);
    drive(s8, 1'b1, 2'b00, a, b);
    for (int n = 1; n <= w + 8; n++) begin
      @(negedge clk);
      drive(s8, logic'(n == mid), 2'b11, {32'd0, $urandom}, {32'd0, $urandom});
      obs(s8, bsy, dn, dz, h, l);
      if (first != 0 && n == first + 1) begin
        total++;
        if (bsy !== 1'b0) begin
          bad++;
          $display("FAIL start_in_done w=%0d busy next cycle: got %b want 0", w, bsy);
        end
      end
      if (dn === 1'b1) begin
        dcount++;
        if (dcount == 1) begin
          first = n;
          total++;
          if (h !== eh || l !== el) begin
            bad++;
            $display("FAIL start_while_busy w=%0d hi/lo: got %h/%h want %h/%h", w, h, l, eh, el);
          end
          drive(s8, 1'b1, 2'b11, 64'd100, 64'd7);
        end
      end
    end
    drive(s8, 1'b0, 2'b00, 64'd0, 64'd0);
    total++;
    if (dcount != 1 || first != w + 2) begin
      bad++;
      $display("FAIL start_while_busy w=%0d done pulses/cycle: got %0d/%0d want 1/%0d",
               w, dcount, first, w + 2);
    end
    prev_hi[s8] = eh;
    prev_lo[s8] = el;
  endtask

  task automatic test_reset_mid(input bit s8);
    int w, rc, dcount;
    logic bsy, dn, dz;
    logic [63:0] h, l, m;
    w  = wid(s8);
    m  = wmask(w);
    rc = s8 ? 5 : 15;
    run_op(s8, 2'b01, m, m, "pre_reset_multu");
    @(negedge clk);
    drive(s8, 1'b1, 2'b00, m - 64'd2, 64'd7);
    for (int n = 1; n <= rc + 1; n++) begin
      @(negedge clk);
      drive(s8, 1'b0, 2'b00, 64'd0, 64'd0);
      set_rst(s8, logic'(n == rc));
    end
    obs(s8, bsy, dn, dz, h, l);
    total++;
    if (bsy !== 1'b0 || dn !== 1'b0 || h !== 64'd0 || l !== 64'd0 || dz !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid w=%0d busy/done/dz/hi/lo: got %b/%b/%b/%h/%h want 0/0/0/0/0",
               w, bsy, dn, dz, h, l);
    end
    dcount = 0;
    for (int n = 0; n < w + 10; n++) begin
      @(negedge clk);
      obs(s8, bsy, dn, dz, h, l);
      if (dn !== 1'b0) dcount++;
    end
    total++;
    if (dcount != 0) begin
      bad++;
      $display("FAIL reset_mid w=%0d stray done pulses: got %0d want 0", w, dcount);
    end
    prev_hi[s8] = '0;
    prev_lo[s8] = '0;
    run_op(s8, 2'b10, m - 64'd6, 64'd2, "post_reset_div");
  endtask

  initial begin
    rst32 = 1'b1; rst8 = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_directed(s[0]);
      test_random(s[0], 40);
      test_start_ignored(s[0]);
      test_reset_mid(s[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
